mem_arbiter: RTL and testbench

- Arbitrates between the instruction-fetch and LSU request channels onto the core's single shared memory port.
- Tracks outstanding transactions in order and routes each in-order response back to the requester that issued it.
- Sits between the fetch/LSU stages and the external bus bridge.
- Policy: LSU priority, with a starvation guard for fetch and grant locking until the request handshake completes.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared memory port arbiter: fetch vs LSU, in-order response routing.
// LSU has priority; fetch is forced after STARVE_LIM lost cycles.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_OT     = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid_i,
   output logic              if_req_ready_o,
   input  logic [ADDR_W-1:0] if_req_addr_i,
   input  logic              lsu_req_valid_i,
   output logic              lsu_req_ready_o,
   input  logic [ADDR_W-1:0] lsu_req_addr_i,
   input  logic              lsu_req_we_i,
   input  logic [DATA_W-1:0] lsu_req_wdata_i,
   input  logic [DATA_W/8-1:0] lsu_req_strb_i,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   output logic              mem_req_we_o,
   output logic [DATA_W-1:0] mem_req_wdata_o,
   output logic [DATA_W/8-1:0] mem_req_strb_o,
   input  logic              mem_rsp_valid_i,
   output logic              mem_rsp_ready_o,
   input  logic [DATA_W-1:0] mem_rsp_data_i,
   input  logic              mem_rsp_err_i,
   output logic              if_rsp_valid_o,
   input  logic              if_rsp_ready_i,
   output logic [DATA_W-1:0] if_rsp_data_o,
   output logic              if_rsp_err_o,
   output logic              lsu_rsp_valid_o,
   input  logic              lsu_rsp_ready_i,
   output logic [DATA_W-1:0] lsu_rsp_data_o,
   output logic              lsu_rsp_err_o
);

   localparam int PW = $clog2(MAX_OT);
   localparam int SW = $clog2(STARVE_LIM + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOCK_IF,
      LOCK_LSU
   } state_t;

   state_t state_q, state_d;

   logic          gnt_if, gnt_lsu;
   logic          req_hs, rsp_hs;
   logic          full, empty, head;
   logic          starved;
   logic [MAX_OT-1:0] id_q;
   logic [PW-1:0] wr_q, rd_q;
   logic [PW:0]   cnt_q;
   logic [SW-1:0] starve_q;

   assign full    = (cnt_q == (PW+1)'(MAX_OT));
   assign empty   = (cnt_q == '0);
   assign head    = id_q[rd_q];
   assign starved = (starve_q == SW'(STARVE_LIM));

   // Grant is combinational; reset forces it off so nothing leaks out
   always_comb begin
      gnt_if  = 1'b0;
      gnt_lsu = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!full) begin
               if (lsu_req_valid_i && !(if_req_valid_i && starved))
                  gnt_lsu = 1'b1;
               else if (if_req_valid_i)
                  gnt_if = 1'b1;
            end
         end
         LOCK_IF:  gnt_if  = 1'b1;
         LOCK_LSU: gnt_lsu = 1'b1;
         default: ;
      endcase
      if (!rst) begin
         gnt_if  = 1'b0;
         gnt_lsu = 1'b0;
      end
   end

   assign mem_req_valid_o = (gnt_if & if_req_valid_i)
                          | (gnt_lsu & lsu_req_valid_i);
   assign if_req_ready_o  = gnt_if & mem_req_ready_i;
   assign lsu_req_ready_o = gnt_lsu & mem_req_ready_i;
   assign req_hs          = mem_req_valid_o & mem_req_ready_i;

   assign mem_req_addr_o  = gnt_lsu ? lsu_req_addr_i : if_req_addr_i;
   assign mem_req_we_o    = gnt_lsu & lsu_req_we_i;
   assign mem_req_wdata_o = gnt_lsu ? lsu_req_wdata_i : '0;
   assign mem_req_strb_o  = gnt_lsu ? lsu_req_strb_i : '0;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_if && if_req_valid_i && !mem_req_ready_i)
               state_d = LOCK_IF;
            else if (gnt_lsu && lsu_req_valid_i && !mem_req_ready_i)
               state_d = LOCK_LSU;
         end
         LOCK_IF, LOCK_LSU: begin
            if (req_hs)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         starve_q <= '0;
      else if (!if_req_valid_i || (gnt_if && req_hs))
         starve_q <= '0;
      else if (gnt_lsu && !starved)
         starve_q <= starve_q + 1'b1;
   end

   // In-order ID FIFO: 0 = fetch, 1 = LSU
   assign rsp_hs = mem_rsp_valid_i & mem_rsp_ready_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_q  <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (req_hs) begin
            id_q[wr_q] <= gnt_lsu;
            wr_q       <= wr_q + 1'b1;
         end
         if (rsp_hs)
            rd_q <= rd_q + 1'b1;
         if (req_hs && !rsp_hs)
            cnt_q <= cnt_q + 1'b1;
         else if (!req_hs && rsp_hs)
            cnt_q <= cnt_q - 1'b1;
      end
   end

   assign mem_rsp_ready_o = !empty
                          && (head ? lsu_rsp_ready_i : if_rsp_ready_i);
   assign if_rsp_valid_o  = mem_rsp_valid_i && !empty && !head;
   assign lsu_rsp_valid_o = mem_rsp_valid_i && !empty && head;
   assign if_rsp_data_o   = mem_rsp_data_i;
   assign if_rsp_err_o    = mem_rsp_err_i;
   assign lsu_rsp_data_o  = mem_rsp_data_i;
   assign lsu_rsp_err_o   = mem_rsp_err_i;

`ifndef SYNTHESIS
   a_rsp_without_ot: assert property (
      @(posedge clk) disable iff (!rst)
      !(mem_rsp_valid_i && empty));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, starvation,
// locking, FIFO full, response backpressure and reset.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid_i;
   logic        if_req_ready_o;
   logic [31:0] if_req_addr_i;
   logic        lsu_req_valid_i;
   logic        lsu_req_ready_o;
   logic [31:0] lsu_req_addr_i;
   logic        lsu_req_we_i;
   logic [31:0] lsu_req_wdata_i;
   logic [3:0]  lsu_req_strb_i;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [31:0] mem_req_addr_o;
   logic        mem_req_we_o;
   logic [31:0] mem_req_wdata_o;
   logic [3:0]  mem_req_strb_o;
   logic        mem_rsp_valid_i;
   logic        mem_rsp_ready_o;
   logic [31:0] mem_rsp_data_i;
   logic        mem_rsp_err_i;
   logic        if_rsp_valid_o;
   logic        if_rsp_ready_i;
   logic [31:0] if_rsp_data_o;
   logic        if_rsp_err_o;
   logic        lsu_rsp_valid_o;
   logic        lsu_rsp_ready_i;
   logic [31:0] lsu_rsp_data_o;
   logic        lsu_rsp_err_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_OT(4), .STARVE_LIM(8)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req_valid_i(if_req_valid_i),
      .if_req_ready_o(if_req_ready_o),
      .if_req_addr_i(if_req_addr_i),
      .lsu_req_valid_i(lsu_req_valid_i),
      .lsu_req_ready_o(lsu_req_ready_o),
      .lsu_req_addr_i(lsu_req_addr_i),
      .lsu_req_we_i(lsu_req_we_i),
      .lsu_req_wdata_i(lsu_req_wdata_i),
      .lsu_req_strb_i(lsu_req_strb_i),
      .mem_req_valid_o(mem_req_valid_o),
      .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o(mem_req_addr_o),
      .mem_req_we_o(mem_req_we_o),
      .mem_req_wdata_o(mem_req_wdata_o),
      .mem_req_strb_o(mem_req_strb_o),
      .mem_rsp_valid_i(mem_rsp_valid_i),
      .mem_rsp_ready_o(mem_rsp_ready_o),
      .mem_rsp_data_i(mem_rsp_data_i),
      .mem_rsp_err_i(mem_rsp_err_i),
      .if_rsp_valid_o(if_rsp_valid_o),
      .if_rsp_ready_i(if_rsp_ready_i),
      .if_rsp_data_o(if_rsp_data_o),
      .if_rsp_err_o(if_rsp_err_o),
      .lsu_rsp_valid_o(lsu_rsp_valid_o),
      .lsu_rsp_ready_i(lsu_rsp_ready_i),
      .lsu_rsp_data_o(lsu_rsp_data_o),
      .lsu_rsp_err_o(lsu_rsp_err_o)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // let combinational outputs settle mid-cycle
   task automatic settle();
      #3;
   endtask

   initial begin
      rst             = 1'b0;
      if_req_valid_i  = 1'b1;
      if_req_addr_i   = 32'h0;
      lsu_req_valid_i = 1'b1;
      lsu_req_addr_i  = 32'h2000;
      lsu_req_we_i    = 1'b1;
      lsu_req_wdata_i = 32'h55;
      lsu_req_strb_i  = 4'hf;
      mem_req_ready_i = 1'b1;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = 32'h0;
      mem_rsp_err_i   = 1'b0;
      if_rsp_ready_i  = 1'b1;
      lsu_rsp_ready_i = 1'b1;

      // reset holds everything quiet
      tick();
      settle();
      chk("rst_mvalid", mem_req_valid_o, 0);
      chk("rst_ifrdy", if_req_ready_o, 0);
      chk("rst_lsurdy", lsu_req_ready_o, 0);
      chk("rst_ifrsp", if_rsp_valid_o, 0);
      if_req_valid_i  = 1'b0;
      lsu_req_valid_i = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // fetch only
      if_req_valid_i = 1'b1;
      if_req_addr_i  = 32'h1000;
      settle();
      chk("f_valid", mem_req_valid_o, 1);
      chk("f_addr", mem_req_addr_o, 32'h1000);
      chk("f_we", mem_req_we_o, 0);
      chk("f_rdy", if_req_ready_o, 1);
      chk("f_lsurdy", lsu_req_ready_o, 0);
      tick();
      if_req_valid_i  = 1'b0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'hdeadbeef;
      settle();
      chk("f_rspv", if_rsp_valid_o, 1);
      chk("f_rspd", if_rsp_data_o, 32'hdeadbeef);
      chk("f_lsurspv", lsu_rsp_valid_o, 0);
      chk("f_mrsprdy", mem_rsp_ready_o, 1);
      tick();
      mem_rsp_valid_i = 1'b0;

      // both valid: LSU wins 8, fetch wins the 9th
      if_req_valid_i  = 1'b1;
      lsu_req_valid_i = 1'b1;
      if_req_addr_i   = 32'h1100;
      for (int c = 0; c < 18; c++) begin
         automatic bit exp_if = ((c % 9) == 8);
         automatic bit prv_if = ((c % 9) == 0) && (c > 0);
         mem_rsp_valid_i = (c > 0);
         settle();
         chk("s_addr", mem_req_addr_o,
             exp_if ? 32'h1100 : 32'h2000);
         chk("s_ifrdy", if_req_ready_o, exp_if);
         if (c == 0) begin
            chk("s_we", mem_req_we_o, 1);
            chk("s_wd", mem_req_wdata_o, 32'h55);
            chk("s_strb", mem_req_strb_o, 4'hf);
         end
         if (c > 0) begin
            chk("s_rif", if_rsp_valid_o, prv_if);
            chk("s_rlsu", lsu_rsp_valid_o, !prv_if);
         end
         tick();
      end
      if_req_valid_i  = 1'b0;
      lsu_req_valid_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      settle();
      chk("s_drain_if", if_rsp_valid_o, 1);
      chk("s_drain_lsu", lsu_rsp_valid_o, 0);
      tick();
      mem_rsp_valid_i = 1'b0;

      // fetch locked while ready is low
      if_req_valid_i  = 1'b1;
      if_req_addr_i   = 32'h3000;
      mem_req_ready_i = 1'b0;
      settle();
      chk("l_addr0", mem_req_addr_o, 32'h3000);
      chk("l_ifrdy0", if_req_ready_o, 0);
      tick();
      lsu_req_valid_i = 1'b1;
      lsu_req_we_i    = 1'b0;
      for (int c = 1; c < 3; c++) begin
         settle();
         chk("l_addr", mem_req_addr_o, 32'h3000);
         chk("l_lsurdy", lsu_req_ready_o, 0);
         tick();
      end
      mem_req_ready_i = 1'b1;
      settle();
      chk("l_hs_addr", mem_req_addr_o, 32'h3000);
      chk("l_hs_rdy", if_req_ready_o, 1);
      tick();
      if_req_valid_i = 1'b0;
      settle();
      chk("l_lsu_addr", mem_req_addr_o, 32'h2000);
      chk("l_lsu_rdy", lsu_req_ready_o, 1);
      tick();
      lsu_req_valid_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      settle();
      chk("l_r0", if_rsp_valid_o, 1);
      tick();
      settle();
      chk("l_r1", lsu_rsp_valid_o, 1);
      tick();
      mem_rsp_valid_i = 1'b0;

      // fill four outstanding, fifth blocked
      if_req_valid_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if_req_addr_i = 32'h4000 + 32'(c * 4);
         settle();
         chk("o_rdy", if_req_ready_o, 1);
         tick();
      end
      if_req_addr_i = 32'h4010;
      settle();
      chk("o_full_v", mem_req_valid_o, 0);
      chk("o_full_r", if_req_ready_o, 0);
      tick();
      mem_rsp_valid_i = 1'b1;
      settle();
      chk("o_pop_v", mem_req_valid_o, 0);
      chk("o_pop_rr", mem_rsp_ready_o, 1);
      tick();
      mem_rsp_valid_i = 1'b0;
      settle();
      chk("o_5th_v", mem_req_valid_o, 1);
      chk("o_5th_a", mem_req_addr_o, 32'h4010);
      tick();
      if_req_valid_i  = 1'b0;
      mem_rsp_valid_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         settle();
         chk("o_drain", if_rsp_valid_o, 1);
         tick();
      end
      mem_rsp_valid_i = 1'b0;

      // LSU response backpressure with error
      lsu_req_valid_i = 1'b1;
      lsu_req_we_i    = 1'b1;
      tick();
      lsu_req_valid_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_err_i   = 1'b1;
      lsu_rsp_ready_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk("b_mrr", mem_rsp_ready_o, 0);
         chk("b_lv", lsu_rsp_valid_o, 1);
         tick();
      end
      lsu_rsp_ready_i = 1'b1;
      settle();
      chk("b_mrr3", mem_rsp_ready_o, 1);
      chk("b_err", lsu_rsp_err_o, 1);
      chk("b_ifv", if_rsp_valid_o, 0);
      tick();
      mem_rsp_valid_i = 1'b0;
      mem_rsp_err_i   = 1'b0;

      // reset with 2 outstanding and fetch locked
      if_req_valid_i = 1'b1;
      tick();
      if_req_valid_i  = 1'b0;
      lsu_req_valid_i = 1'b1;
      lsu_req_we_i    = 1'b0;
      tick();
      lsu_req_valid_i = 1'b0;
      if_req_valid_i  = 1'b1;
      mem_req_ready_i = 1'b0;
      tick();
      lsu_req_valid_i = 1'b1;
      rst = 1'b0;
      #1;
      chk("r_mv", mem_req_valid_o, 0);
      chk("r_ifr", if_req_ready_o, 0);
      chk("r_lr", lsu_req_ready_o, 0);
      chk("r_mrr", mem_rsp_ready_o, 0);
      chk("r_lsv", lsu_rsp_valid_o, 0);
      tick();
      mem_req_ready_i = 1'b1;
      rst = 1'b1;
      settle();
      chk("r_idle", mem_req_addr_o, 32'h2000);
      tick();
      lsu_req_valid_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("r_fill", if_req_ready_o, 1);
         tick();
      end
      settle();
      chk("r_full", mem_req_valid_o, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
